// File: rtl/mem_dump_reader_pkg.sv
// Shared definitions for the data-memory dump reader.
// Holds the FSM state encoding, the word stride and the default widths.
package mem_dump_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_CNT_W   = 16;
    localparam int WORD_STRIDE = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT,
        FINISH
    } dumpState_t;

    function automatic logic isWordAligned(input logic [1:0] adrLsb);
        return adrLsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_dump_reader_if.sv
// Data-memory read port and dump stream bundled between the reader and its surroundings.
// The master side is the reader; the slave side is the memory/consumer.
interface mem_dump_reader_if
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_adr;
    logic [31:0]       mem_rdata;
    logic              dump_valid;
    logic              dump_ready;
    logic [31:0]       dump_data;
    logic [ADDR_W-1:0] dump_adr;

    modport master (
        output mem_rd_en,
        output mem_adr,
        input  mem_rdata,
        output dump_valid,
        input  dump_ready,
        output dump_data,
        output dump_adr
    );

    modport slave (
        input  mem_rd_en,
        input  mem_adr,
        output mem_rdata,
        input  dump_valid,
        output dump_ready,
        input  dump_data,
        input  dump_adr
    );

endinterface

// File: rtl/mem_dump_reader.sv
// Streams a block of 32-bit words out of data memory, one word per two cycles.
// Borrows the data-memory address only while fetching; the top level muxes it in.
module mem_dump_reader
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_adr,
    input  logic [CNT_W-1:0]   word_count,
    mem_dump_reader_if.master  bus,
    output logic               busy,
    output logic               done,
    output logic               err
);

    dumpState_t        state;
    dumpState_t        nextState;
    logic [ADDR_W-1:0] curAdr;
    logic [CNT_W-1:0]  remaining;
    logic [31:0]       dumpData;
    logic [ADDR_W-1:0] dumpAdr;
    logic              errPulse;
    logic              zeroDone;

    logic acceptStart;
    logic rejectStart;
    logic emptyStart;
    logic handshake;

    always_comb begin
        nextState   = state;
        acceptStart = 1'b0;
        rejectStart = 1'b0;
        emptyStart  = 1'b0;
        handshake   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!isWordAligned(base_adr[1:0])) begin
                        rejectStart = 1'b1;
                    end else if (word_count == '0) begin
                        emptyStart = 1'b1;
                    end else begin
                        acceptStart = 1'b1;
                        nextState   = FETCH;
                    end
                end
            end
            FETCH: nextState = PRESENT;
            PRESENT: begin
                if (bus.dump_ready) begin
                    handshake = 1'b1;
                    nextState = (remaining == CNT_W'(1)) ? FINISH : FETCH;
                end
            end
            FINISH:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            curAdr    <= '0;
            remaining <= '0;
            dumpData  <= '0;
            dumpAdr   <= '0;
            errPulse  <= 1'b0;
            zeroDone  <= 1'b0;
        end else begin
            state    <= nextState;
            errPulse <= rejectStart;
            zeroDone <= emptyStart;
            if (acceptStart) begin
                curAdr    <= base_adr;
                remaining <= word_count;
            end
            // Memory read data is combinational from curAdr, so capture it at the end of FETCH.
            if (state == FETCH) begin
                dumpData <= bus.mem_rdata;
                dumpAdr  <= curAdr;
            end
            // The last word leaves curAdr and remaining untouched; counting down stops at 1.
            if (handshake && remaining != CNT_W'(1)) begin
                remaining <= remaining - CNT_W'(1);
                curAdr    <= curAdr + ADDR_W'(WORD_STRIDE);
            end
        end
    end

    assign bus.mem_rd_en  = (state == FETCH);
    assign bus.mem_adr    = curAdr;
    assign bus.dump_valid = (state == PRESENT);
    assign bus.dump_data  = dumpData;
    assign bus.dump_adr   = dumpAdr;
    assign busy           = (state != IDLE);
    assign done           = (state == FINISH) || zeroDone;
    assign err            = errPulse;

endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 Parameter ADDR_W, default 32, is the byte-address width.
REQ-002 Parameter CNT_W, default 16, is the word-count width.
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  is the reset: synchronous, active-high.
REQ-005 start  input  1  is a one-cycle request to begin a dump.
REQ-006 base_adr  input  ADDR_W  is the first byte address of the dump, word-aligned.
REQ-007 word_count  input  CNT_W  is the number of 32-bit words to dump.
REQ-008 mem_rd_en  output  1  is high while the block owns the data-memory address; the top level muxes mem_adr onto DataAdr when it is high.
REQ-009 mem_adr  output  ADDR_W  is the data-memory read address.
REQ-010 mem_rdata  input  32  is the data-memory ReadData, combinational from mem_adr, with word access.
REQ-011 dump_valid  output  1  is the stream valid.
REQ-012 dump_ready  input  1  is the stream ready from the consumer.
REQ-013 dump_data  output  32  is the captured word.
REQ-014 dump_adr  output  ADDR_W  is the byte address of dump_data.
REQ-015 busy  output  1  is high from acceptance of start until the done pulse.
REQ-016 done  output  1  is a one-cycle pulse when the dump completes.
REQ-017 err  output  1  is a one-cycle pulse when start is rejected.

Function
REQ-018 The FSM SHALL have the states IDLE, FETCH, PRESENT and FINISH.
REQ-019 IDLE with start=1, base_adr[1:0]=0 and word_count!=0: the block SHALL latch cur_adr=base_adr and remaining=word_count, and go to FETCH.
REQ-020 IDLE with start=1 and base_adr[1:0]!=0: err SHALL pulse for 1 cycle, and the state SHALL stay IDLE.
REQ-021 IDLE with start=1, aligned base_adr and word_count=0: done SHALL pulse for 1 cycle, busy SHALL stay 0, and the state SHALL stay IDLE.
REQ-022 In FETCH, mem_rd_en=1 and mem_adr=cur_adr; on the next edge dump_data<=mem_rdata, dump_adr<=cur_adr, and the state goes to PRESENT.
REQ-023 In PRESENT, dump_valid=1, and dump_data and dump_adr SHALL stay stable until dump_valid&&dump_ready.
REQ-024 Handshake in PRESENT with remaining>1: remaining-=1, cur_adr+=4 (mod 2^ADDR_W, wrap allowed), and the state goes to FETCH.
REQ-025 Handshake in PRESENT with remaining=1: the state goes to FINISH.
REQ-026 In FINISH, done=1 for exactly 1 cycle, then the state returns to IDLE.
REQ-027 busy SHALL be 1 in FETCH, PRESENT and FINISH, and 0 in IDLE.
REQ-028 mem_rd_en SHALL be 1 only in FETCH.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 dump_valid SHALL NOT be deasserted without a handshake, except on reset.
REQ-031 Throughput SHALL be at most 1 word per 2 cycles; latency from an accepted start to the first dump_valid SHALL be 2 cycles.
REQ-032 mem_adr SHALL equal cur_adr in all states, so it is stable for mux glitch analysis.
REQ-033 remaining SHALL be CNT_W bits wide, and a word_count of 2^CNT_W-1 SHALL complete without overflow.

Reset
REQ-034 While reset=1 at a clock edge, the state SHALL become IDLE; cur_adr, remaining, dump_data and dump_adr SHALL be 0; dump_valid, busy, done, err and mem_rd_en SHALL be 0.
REQ-035 Reset during FETCH or PRESENT SHALL abort the dump without a done pulse, and any pending word SHALL be dropped.
REQ-036 start sampled in the same cycle as reset=1 SHALL be ignored.

Structure
REQ-037 A shared package mem_dump_pkg SHALL hold the state enumeration, the word stride constant (4) and the default ADDR_W and CNT_W values.
REQ-038 The design SHALL be a single module with no sub-module; the top level instantiates it beside data_mem and adds mem_rd_en to the DataAdr mux.

Verification
REQ-039 Preload 0x0, 0x4 and 0x8 with 0x11111111, 0x22222222 and 0x33333333, hold dump_ready=1, and start with base=0x0 and count=3. Required response: three beats with dump_adr 0x0/0x4/0x8 carrying those data, beats 2 cycles apart, then done 1 cycle after the 3rd handshake.
REQ-040 Start with base=0x10 and count=2, holding dump_ready=0 for 5 cycles after the first dump_valid. Required response: dump_data and dump_adr stay constant for 5 cycles, and no address advance occurs.
REQ-041 Start with base=0x6 and count=4. Required response: err pulses 1 cycle, busy stays 0, and mem_rd_en never rises.
REQ-042 Start with base=0x0 and count=0. Required response: done pulses 1 cycle, and no dump_valid occurs.
REQ-043 Start with base=0xFFFFFFFC and count=2. Required response: dump_adr sequence 0xFFFFFFFC then 0x00000000.
REQ-044 Assert reset for 1 cycle during PRESENT of word 2 of a 5-word dump. Required response: all outputs 0 the next cycle, no done pulse, and a new start is accepted normally.
